fetch_issuer: RTL
=================

Name: fetch_issuer

Overview:
- Instruction-fetch front end that acts as the producer side of the instruction fetch buffer.
- Generates sequential AHB-Lite-style instruction read requests and captures the responses.
- Pushes each fetched word, its status and its checksum into the fetch buffer.
- Never issues a request the buffer cannot absorb; discards in-flight responses on flush/redirect.

Parameters:
- IFB_SIZE, 2, number of fetch-buffer entries; used for credit accounting.
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset.

Ports:
- s_clk_i  input  1  clock
- s_resetn_i  input  1  reset; asynchronous, active-low
- s_flush_i  input  1  redirect/flush request
- s_flush_addr_i  input  32  new fetch address on flush (bits [1:0] ignored, treated as 0)
- s_occupied_i  input  IFB_SIZE  fetch-buffer entry occupancy
- s_hready_i  input  1  bus ready
- s_hresp_i  input  1  bus error response for the current data phase
- s_hrdata_i  input  32  bus read data
- s_haddr_o  output  32  bus address
- s_htrans_o  output  2  bus transfer type: 2'b00 IDLE, 2'b10 NONSEQ
- s_push_o  output  1  push strobe to the fetch buffer
- s_data_o  output  IFB_WIDTH  entry to push
- s_checksum_o  output  7  checksum of s_data_o[31:0]

Behaviour:
- Reset values (asynchronous):
  - PC = BOOT_ADDR; s_haddr_o = BOOT_ADDR; s_htrans_o = IDLE.
  - s_push_o = 0; s_data_o = 0; s_checksum_o = 0; all internal flags 0.
- State machine: BOOT -> RUN.
  - BOOT lasts exactly the first clock edge after reset release and drives IDLE.
  - From the cycle after that edge, the block is in RUN permanently.
- Address phase:
  - s_haddr_o = PC at all times.
  - s_htrans_o = NONSEQ iff state is RUN, s_flush_i = 0 and credit is available; otherwise IDLE.
  - Address phase is accepted when NONSEQ and s_hready_i = 1. On acceptance: PC <= PC + 4 (32-bit wrap), dph_pend <= 1, dph_discard <= 0.
  - While s_hready_i = 0, PC, s_haddr_o and the NONSEQ request hold stable.
- Credit:
  - free = IFB_SIZE - popcount(s_occupied_i).
  - inflight = dph_pend (data phase outstanding) + push_q (registered push not yet visible in occupancy).
  - Issue only if free > inflight.
  - Pops in the same cycle are ignored; accounting is conservative and the buffer never overflows.
- Data phase:
  - Completes at the edge where dph_pend = 1 and s_hready_i = 1.
  - If the data phase completes and dph_discard = 0: next cycle s_push_o = 1, s_data_o[31:0] = captured s_hrdata_i.
  - s_data_o[35:33] = FETCH_VALID, or FETCH_BUSERR when s_hresp_i = 1 (data field still pushed).
  - s_data_o[37:36] = 2'b00 (no RAS prediction); s_data_o[32] = 0.
  - dph_pend clears unless a new address phase is accepted in the same cycle (back-to-back pipelining allowed).
- Push latency: exactly 1 cycle after data-phase completion; s_push_o is a single-cycle pulse per fetched word.
- Flush (s_flush_i = 1):
  - PC <= {s_flush_addr_i[31:2], 2'b00}.
  - s_htrans_o forced IDLE that cycle.
  - An outstanding or simultaneously completing data phase is discarded (dph_discard <= 1 if still pending); no push results from it.
  - A push already registered (s_push_o = 1 this cycle) still occurs; the fetch buffer's flush clears it.
  - First NONSEQ to the new address appears the cycle after the flush, subject to credit.
- Flush during BOOT: the flush address overrides BOOT_ADDR.
- Reset mid-transfer: all state is dropped immediately; no push on release.

Optional Feature:
- Macro: FETCH_CHECKSUM_EN.
- Defined:
  - s_checksum_o = SECDED checksum (the team's secded_encode) of the captured s_hrdata_i, registered alongside s_data_o.
  - Checksum is valid in the same cycle as s_push_o.
- Undefined:
  - s_checksum_o tied to 7'h00; no encoder instantiated.
  - All other behaviour identical.

Test Plan:
- Reset release, hready = 1, buffer empty, hrdata = 32'h0000_0013 -> NONSEQ at BOOT_ADDR, next at BOOT_ADDR+4; s_push_o pulses with data 32'h0000_0013, status FETCH_VALID.
- IFB_SIZE = 2, s_occupied_i = 2'b11 held -> s_htrans_o stays IDLE; after s_occupied_i = 2'b01 -> exactly one NONSEQ, then IDLE until a push plus pop frees space.
- s_hready_i = 0 for 3 cycles during a NONSEQ to 0x100 -> s_haddr_o stable at 0x100 and PC unchanged; acceptance on the 4th cycle -> PC = 0x104.
- Flush with s_flush_addr_i = 32'h0000_2003 while a data phase is pending -> that response is not pushed; next NONSEQ is at 32'h0000_2000.
- s_hresp_i = 1 on the data phase -> push with status FETCH_BUSERR; the next sequential fetch continues.
- FETCH_CHECKSUM_EN defined, hrdata = 32'hDEAD_BEEF -> s_checksum_o equals the secded_encode(32'hDEAD_BEEF) value during s_push_o; undefined -> 7'h00.

Source files
------------

// File: rtl/fetch_issuer.sv
// Instruction-fetch producer for the fetch buffer: credit-gated sequential AHB-Lite reads, responses pushed with status.
// Optional macro FETCH_CHECKSUM_EN registers a SECDED checksum of each fetched word; otherwise s_checksum_o is 0.
module fetch_issuer #(
    parameter int unsigned IFB_SIZE  = 2,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    localparam int unsigned IFB_WIDTH = 38
) (
    input  logic                 s_clk_i,
    input  logic                 s_resetn_i,
    input  logic                 s_flush_i,
    input  logic [31:0]          s_flush_addr_i,
    input  logic [IFB_SIZE-1:0]  s_occupied_i,
    input  logic                 s_hready_i,
    input  logic                 s_hresp_i,
    input  logic [31:0]          s_hrdata_i,
    output logic [31:0]          s_haddr_o,
    output logic [1:0]           s_htrans_o,
    output logic                 s_push_o,
    output logic [IFB_WIDTH-1:0] s_data_o,
    output logic [6:0]           s_checksum_o
);

    localparam int unsigned CW = $clog2(IFB_SIZE + 1) + 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] FETCH_VALID   = 3'b001;
    localparam logic [2:0] FETCH_BUSERR  = 3'b010;

    typedef enum logic {ST_BOOT, ST_RUN} state_e;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic                 dph_pend_q, dph_pend_d;
    logic                 dph_discard_q, dph_discard_d;
    logic                 push_q, push_d;
    logic [IFB_WIDTH-1:0] data_q, data_d;

    logic [CW-1:0]        occ_cnt, free_cnt, inflight;
    logic                 issue, addr_accept, dph_done;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^s_flush_addr_i[1:0];

    // Conservative credit: same-cycle pops are not counted, so the buffer never overflows.
    always_comb begin
        occ_cnt  = CW'($countones(s_occupied_i));
        free_cnt = CW'(IFB_SIZE) - occ_cnt;
        inflight = CW'(dph_pend_q) + CW'(push_q);
    end

    assign issue       = (state_q == ST_RUN) && !s_flush_i && (free_cnt > inflight);
    assign addr_accept = issue && s_hready_i;
    assign dph_done    = dph_pend_q && s_hready_i;

    assign s_haddr_o  = pc_q;
    assign s_htrans_o = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_push_o   = push_q;
    assign s_data_o   = data_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        dph_pend_d    = dph_pend_q;
        dph_discard_d = dph_discard_q;
        push_d        = 1'b0;
        data_d        = data_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (dph_done) begin
            dph_pend_d = 1'b0;
            if (!dph_discard_q && !s_flush_i) begin
                push_d = 1'b1;
                data_d = {2'b00, (s_hresp_i ? FETCH_BUSERR : FETCH_VALID), 1'b0, s_hrdata_i};
            end
        end

        // A flush leaves a stalled data phase outstanding but marks its response as dead.
        if (s_flush_i) begin
            pc_d          = {s_flush_addr_i[31:2], 2'b00};
            dph_discard_d = dph_pend_q && !dph_done;
        end else if (addr_accept) begin
            pc_d          = pc_q + 32'd4;
            dph_pend_d    = 1'b1;
            dph_discard_d = 1'b0;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= BOOT_ADDR;
            dph_pend_q    <= 1'b0;
            dph_discard_q <= 1'b0;
            push_q        <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            dph_pend_q    <= dph_pend_d;
            dph_discard_q <= dph_discard_d;
            push_q        <= push_d;
            data_q        <= data_d;
        end
    end

`ifdef FETCH_CHECKSUM_EN
    // Hamming(38,32) check bits over non-power-of-two positions 1..38, plus overall parity in bit 6.
    function automatic logic [6:0] secded_encode(input logic [31:0] d);
        logic [6:0]  c;
        int unsigned k;
        c = '0;
        k = 0;
        for (int unsigned p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int unsigned j = 0; j < 6; j++) begin
                    if (p[j[4:0]]) c[j[2:0]] = c[j[2:0]] ^ d[k[4:0]];
                end
                k++;
            end
        end
        c[6] = ^{d, c[5:0]};
        return c;
    endfunction

    logic [6:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (dph_done && !dph_discard_q && !s_flush_i) chk_d = secded_encode(s_hrdata_i);
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) chk_q <= '0;
        else             chk_q <= chk_d;
    end

    assign s_checksum_o = chk_q;
`else
    assign s_checksum_o = 7'h00;
`endif

endmodule
